hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
Pipeline interlock controller for the 5-stage MIPS core. It is the stalling counterpart of the forwarding unit: it handles the dependencies that bypass cannot resolve. It compares the ID-stage source registers against the EX and MEM destinations and freezes PC and IF/ID. It also injects bubbles into ID/EX and tracks multi-cycle stalls with a small state machine and a saturating stall-cycle counter.

Parameters:
CNT_W, 16, width of the stall-cycle performance counter
BRANCH_IN_ID, 1, 1 means branches resolve in ID and need EX/MEM operands; 0 disables branch interlocks

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_rs  input  5  rs field of the instruction in ID
id_rt  input  5  rt field of the instruction in ID
id_uses_rt  input  1  ID instruction reads rt (R-type, beq/bne, sw)
id_is_branch  input  1  ID instruction is beq/bne
ex_rd  input  5  destination register of the instruction in EX
ex_reg_write  input  1  EX instruction writes the register file
ex_mem_to_reg  input  1  EX instruction is a load
mem_rd  input  5  destination register of the instruction in MEM
mem_reg_write  input  1  MEM instruction writes the register file
mem_mem_to_reg  input  1  MEM instruction is a load
mem_busy  input  1  data memory not ready; freezes the whole pipeline
pc_write  output  1  PC update enable (0 = hold)
ifid_write  output  1  IF/ID register enable (0 = hold)
idex_flush  output  1  load a bubble (all controls 0) into ID/EX
stall_cnt  output  CNT_W  count of bubble cycles inserted, saturating
busy_state  output  2  current FSM state (00 RUN, 01 HOLD2, 10 FROZEN)

Behaviour:
- Match definitions. Both use ID operand "src" = id_rs, plus id_rt when id_uses_rt=1.
  - match_ex(src): ex_reg_write=1, ex_rd==src, src!=0.
  - match_mem(src): the same test using the mem_* signals.
- Hazard classes, evaluated combinationally in RUN:
  - LU (load-use): ex_mem_to_reg=1 and match_ex on either source. Needs 1 bubble.
  - BA (branch after ALU op): BRANCH_IN_ID=1, id_is_branch=1, ex_mem_to_reg=0, match_ex. Needs 1 bubble.
  - BL (branch after load in EX): BRANCH_IN_ID=1, id_is_branch=1, ex_mem_to_reg=1, match_ex. Needs 2 bubbles.
  - BM (branch after load in MEM): BRANCH_IN_ID=1, id_is_branch=1, mem_mem_to_reg=1, match_mem. Needs 1 bubble.
- Stall output: pc_write=0, ifid_write=0, idex_flush=1, asserted in the same cycle as detection (zero latency, combinational from inputs and state).
- FSM, registered on clk with async reset to RUN:
  - RUN: with no hazard, pc_write=1, ifid_write=1, idex_flush=0. BL stalls and goes to HOLD2. LU, BA or BM stalls and stays in RUN; re-evaluation next cycle sees the new pipeline contents.
  - HOLD2: forced stall for one cycle regardless of the comparators, then return to RUN. This covers the second BL bubble without depending on MEM-stage comparison.
  - FROZEN: entered from any state when mem_busy=1. pc_write=0, ifid_write=0, idex_flush=0, because an external freeze of ID/EX holds state rather than bubbling.
  - Leaving FROZEN: on mem_busy=0, return to the state that was saved on entry. The saved state is a 1-bit register, RUN or HOLD2.
- Priority: mem_busy > HOLD2 > hazard detection.
- stall_cnt increments by 1 on each rising edge where idex_flush=1. It saturates at all-ones and does not wrap.
- Reset:
  - While rst_n=0: state=RUN, saved state=RUN, stall_cnt=0, pc_write=1, ifid_write=1, idex_flush=0, busy_state=00. All comparators are ignored.
  - Reset asserted mid-HOLD2 or mid-FROZEN aborts immediately; there is no pending bubble after release.
- Register $0 never creates a hazard.
- Simultaneous LU and BM: one bubble per cycle, never more than one flush per cycle.

Test Plan:
1. Load-use: ex_rd=5, ex_reg_write=1, ex_mem_to_reg=1, id_rs=5 → same cycle pc_write=0, ifid_write=0, idex_flush=1 for exactly 1 cycle; stall_cnt 0→1; busy_state stays 00.
2. Branch after load: id_is_branch=1, id_rt=7, id_uses_rt=1, ex_rd=7, ex load for 1 cycle, then EX bubble, MEM holds the load → flush for 2 consecutive cycles; busy_state 00→01→00; stall_cnt +2.
3. Zero register and no-write: ex_rd=0, id_rs=0, load in EX → no stall. Also ex_rd=3 with ex_reg_write=0 and id_rs=3 → no stall; stall_cnt unchanged.
4. mem_busy during HOLD2: assert mem_busy for 3 cycles while in HOLD2 → busy_state=10, idex_flush=0, pc_write=0. After release: one HOLD2 cycle with idex_flush=1, then RUN; stall_cnt counts only the flush cycles.
5. Saturation, with CNT_W=4: hold a load-use hazard for 20 cycles → stall_cnt reaches 15 and stays at 15.
6. Async reset: pull rst_n low mid-HOLD2 between clock edges → outputs go immediately to 1/1/0, stall_cnt=0, busy_state=00. After release with no hazard, no bubble is issued.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Pipeline interlock for the 5-stage MIPS core: detects hazards that
// forwarding cannot cover, freezes PC/IF-ID and bubbles ID/EX.
module hazard_stall_unit #(
  parameter int CNT_W        = 16,
  parameter bit BRANCH_IN_ID = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_to_reg,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_mem_to_reg,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       busy_state
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    HOLD2  = 2'b01,
    FROZEN = 2'b10
  } state_t;

  state_t state, next_state;
  logic   saved_hold2, next_saved_hold2;

  logic match_ex, match_mem;
  logic haz_lu, haz_ba, haz_bl, haz_bm, hazard;

  // Register $0 is hardwired to zero, so it never matches a producer.
  assign match_ex  = ex_reg_write &&
                     (((ex_rd == id_rs) && (id_rs != 5'd0)) ||
                      (id_uses_rt && (ex_rd == id_rt) && (id_rt != 5'd0)));
  assign match_mem = mem_reg_write &&
                     (((mem_rd == id_rs) && (id_rs != 5'd0)) ||
                      (id_uses_rt && (mem_rd == id_rt) && (id_rt != 5'd0)));

  assign haz_lu = ex_mem_to_reg && match_ex;
  assign haz_ba = BRANCH_IN_ID && id_is_branch && !ex_mem_to_reg && match_ex;
  assign haz_bl = BRANCH_IN_ID && id_is_branch && ex_mem_to_reg && match_ex;
  assign haz_bm = BRANCH_IN_ID && id_is_branch && mem_mem_to_reg && match_mem;
  assign hazard = haz_lu || haz_ba || haz_bl || haz_bm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      saved_hold2 <= 1'b0;
    end else begin
      state       <= next_state;
      saved_hold2 <= next_saved_hold2;
    end
  end

  // Priority is memory freeze, then the forced second BL bubble, then the
  // comparators; reset overrides everything so outputs are clean while held.
  always_comb begin
    next_state       = state;
    next_saved_hold2 = saved_hold2;
    pc_write         = 1'b1;
    ifid_write       = 1'b1;
    idex_flush       = 1'b0;
    if (!rst_n) begin
      next_state       = RUN;
      next_saved_hold2 = 1'b0;
    end else if (mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      next_state = FROZEN;
      if (state != FROZEN) next_saved_hold2 = (state == HOLD2);
    end else begin
      case (state)
        FROZEN: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          next_state = saved_hold2 ? HOLD2 : RUN;
        end
        HOLD2: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          next_state = RUN;
        end
        RUN: begin
          if (hazard) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end
          if (haz_bl) next_state = HOLD2;
        end
        default: next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (idex_flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign busy_state = state;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: vector table for the single-cycle
// hazard classes plus sequences for HOLD2, freeze, saturation and reset.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_uses_rt, id_is_branch, ex_reg_write, ex_mem_to_reg;
  logic       mem_reg_write, mem_mem_to_reg, mem_busy;
  logic       pc_write, ifid_write, idex_flush;
  logic [3:0] stall_cnt;
  logic [1:0] busy_state;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_cnt = 4'd0;

  typedef struct {
    logic [4:0] rs, rt;
    logic       uses_rt, is_branch;
    logic [4:0] ex_rd;
    logic       ex_rw, ex_m2r;
    logic [4:0] mem_rd;
    logic       mem_rw, mem_m2r;
    logic       stall;
  } vec_t;

  vec_t vecs[13];

  hazard_stall_unit #(.CNT_W(4), .BRANCH_IN_ID(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_busy(mem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_flush(idex_flush),
    .stall_cnt(stall_cnt), .busy_state(busy_state)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                               input logic uses_rt, input logic is_branch,
                               input logic [4:0] erd, input logic erw, input logic em2r,
                               input logic [4:0] mrd, input logic mrw, input logic mm2r,
                               input logic busy);
    id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; id_is_branch = is_branch;
    ex_rd = erd; ex_reg_write = erw; ex_mem_to_reg = em2r;
    mem_rd = mrd; mem_reg_write = mrw; mem_mem_to_reg = mm2r;
    mem_busy = busy;
  endtask

  task automatic checkOutput(input string name, input logic e_pc, input logic e_ifid,
                             input logic e_flush, input logic [1:0] e_state);
    logic [8:0] act, exp;
    act = {pc_write, ifid_write, idex_flush, busy_state, stall_cnt};
    exp = {e_pc, e_ifid, e_flush, e_state, exp_cnt};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: pc/ifid/flush/state/cnt got %b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
               name, pc_write, ifid_write, idex_flush, busy_state, stall_cnt,
               e_pc, e_ifid, e_flush, e_state, exp_cnt);
    end
  endtask

  // Check combinational outputs mid-cycle, then advance one edge and update
  // the saturating bubble-count model.
  task automatic cycle(input string name, input logic e_pc, input logic e_ifid,
                       input logic e_flush, input logic [1:0] e_state);
    @(negedge clk);
    checkOutput(name, e_pc, e_ifid, e_flush, e_state);
    @(posedge clk);
    if (e_flush && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    #1;
  endtask

  task automatic clearInputs();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    //                rs  rt  urt br  exrd erw em2r mrd mrw mm2r stall
    vecs[0]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0};
    vecs[1]  = '{5'd5, 5'd0, 0, 0, 5'd5, 1, 1, 5'd0, 0, 0, 1};
    vecs[2]  = '{5'd5, 5'd0, 0, 0, 5'd0, 0, 0, 5'd5, 1, 1, 0};
    vecs[3]  = '{5'd1, 5'd6, 1, 0, 5'd6, 1, 1, 5'd0, 0, 0, 1};
    vecs[4]  = '{5'd1, 5'd6, 0, 0, 5'd6, 1, 1, 5'd0, 0, 0, 0};
    vecs[5]  = '{5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 5'd0, 0, 0, 0};
    vecs[6]  = '{5'd3, 5'd0, 0, 0, 5'd3, 0, 1, 5'd0, 0, 0, 0};
    vecs[7]  = '{5'd3, 5'd0, 0, 0, 5'd3, 1, 0, 5'd0, 0, 0, 0};
    vecs[8]  = '{5'd4, 5'd2, 1, 1, 5'd4, 1, 0, 5'd0, 0, 0, 1};
    vecs[9]  = '{5'd2, 5'd9, 1, 1, 5'd0, 0, 0, 5'd9, 1, 1, 1};
    vecs[10] = '{5'd2, 5'd9, 1, 1, 5'd0, 0, 0, 5'd9, 1, 0, 0};
    vecs[11] = '{5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 5'd0, 1, 1, 0};
    vecs[12] = '{5'd8, 5'd0, 0, 1, 5'd0, 1, 0, 5'd8, 0, 1, 0};

    // Reset with a live load-use hazard on the inputs: comparators ignored.
    rst_n = 1'b0;
    applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    #12;
    checkOutput("reset_hold", 1'b1, 1'b1, 1'b0, 2'b00);
    clearInputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].is_branch,
                    vecs[i].ex_rd, vecs[i].ex_rw, vecs[i].ex_m2r,
                    vecs[i].mem_rd, vecs[i].mem_rw, vecs[i].mem_m2r, 1'b0);
      cycle($sformatf("vec%0d", i), !vecs[i].stall, !vecs[i].stall, vecs[i].stall, 2'b00);
    end

    // Branch after load in EX: two bubbles via HOLD2.
    applyStimulus(5'd0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle("bl_first", 1'b0, 1'b0, 1'b1, 2'b00);
    applyStimulus(5'd0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    cycle("bl_hold2", 1'b0, 1'b0, 1'b1, 2'b01);
    applyStimulus(5'd0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle("bl_done", 1'b1, 1'b1, 1'b0, 2'b00);

    // mem_busy while in HOLD2: freeze, then resume the pending bubble.
    applyStimulus(5'd0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle("hb_bl", 1'b0, 1'b0, 1'b1, 2'b00);
    applyStimulus(5'd0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1);
    cycle("hb_busy1", 1'b0, 1'b0, 1'b0, 2'b01);
    cycle("hb_busy2", 1'b0, 1'b0, 1'b0, 2'b10);
    cycle("hb_busy3", 1'b0, 1'b0, 1'b0, 2'b10);
    mem_busy = 1'b0;
    cycle("hb_leave", 1'b0, 1'b0, 1'b0, 2'b10);
    cycle("hb_hold2", 1'b0, 1'b0, 1'b1, 2'b01);
    clearInputs();
    cycle("hb_run", 1'b1, 1'b1, 1'b0, 2'b00);

    // mem_busy over a load-use hazard in RUN: no bubble until released.
    applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    cycle("rb_busy1", 1'b0, 1'b0, 1'b0, 2'b00);
    cycle("rb_busy2", 1'b0, 1'b0, 1'b0, 2'b10);
    mem_busy = 1'b0;
    cycle("rb_leave", 1'b0, 1'b0, 1'b0, 2'b10);
    cycle("rb_lu", 1'b0, 1'b0, 1'b1, 2'b00);
    clearInputs();
    cycle("rb_run", 1'b1, 1'b1, 1'b0, 2'b00);

    // Saturation of the 4-bit counter under a held load-use hazard.
    applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle($sformatf("sat%0d", i), 1'b0, 1'b0, 1'b1, 2'b00);
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++;
      $display("[TB] FAIL sat_final: stall_cnt got %0d expected 15", stall_cnt);
    end

    // Asynchronous reset in the middle of HOLD2.
    applyStimulus(5'd0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle("rst_bl", 1'b0, 1'b0, 1'b1, 2'b00);
    #1;
    checkOutput("rst_pre", 1'b0, 1'b0, 1'b1, 2'b01);
    rst_n = 1'b0;
    #1;
    exp_cnt = 4'd0;
    checkOutput("rst_async", 1'b1, 1'b1, 1'b0, 2'b00);
    #1;
    rst_n = 1'b1;
    clearInputs();
    cycle("rst_after1", 1'b1, 1'b1, 1'b0, 2'b00);
    cycle("rst_after2", 1'b1, 1'b1, 1'b0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
